// File: rtl/fcomp_pipe.sv
// Two-stage pipelined floating-point compare/select (FEQ/FLT/FLE/FMIN/FMAX) with valid/ready.
// Define FCOMP_IEEE_EN for IEEE NaN/NV/signed-zero handling; otherwise legacy raw-bit ordering.
module fcomp_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [EXP_W+MAN_W:0]     in_x,
    input  logic [EXP_W+MAN_W:0]     in_y,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic                     out_nv,
    output logic [TAG_W-1:0]         out_tag
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    localparam logic [2:0] OP_FEQ  = 3'd0;
    localparam logic [2:0] OP_FLT  = 3'd1;
    localparam logic [2:0] OP_FLE  = 3'd2;
    localparam logic [2:0] OP_FMIN = 3'd3;
    localparam logic [2:0] OP_FMAX = 3'd4;

    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [W-1:0]     s1_x;
    logic [W-1:0]     s1_y;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [W-1:0]     s2_result;
    logic             s2_nv;
    logic [TAG_W-1:0] s2_tag;

    logic adv1;
    logic adv2;

    assign adv2     = ~s2_valid | out_ready;
    assign adv1     = ~s1_valid | adv2;
    assign in_ready = adv1;

`ifdef FCOMP_IEEE_EN
    logic s1_x_nan, s1_x_snan, s1_x_zero;
    logic s1_y_nan, s1_y_snan, s1_y_zero;

    // Returns {is_nan, is_snan, is_zero}.
    function automatic logic [2:0] classify(input logic [W-1:0] v);
        logic exp_ones;
        logic man_nz;
        exp_ones = &v[W-2:MAN_W];
        man_nz   = |v[MAN_W-1:0];
        return {exp_ones & man_nz, exp_ones & man_nz & ~v[MAN_W-1], ~(|v[W-2:0])};
    endfunction

    always_ff @(posedge clk) begin
        if (adv1) begin
            {s1_x_nan, s1_x_snan, s1_x_zero} <= classify(in_x);
            {s1_y_nan, s1_y_snan, s1_y_zero} <= classify(in_y);
        end
    end
`endif

    logic           sx, sy;
    logic [W-2:0]   mx, my;
    logic           eq, lt;
    logic           any_nan, any_snan;
    logic [W-1:0]   min_v, max_v;
    logic [W-1:0]   res_d;
    logic           nv_d;

    always_comb begin
        sx = s1_x[W-1];
        sy = s1_y[W-1];
        mx = s1_x[W-2:0];
        my = s1_y[W-2:0];
`ifdef FCOMP_IEEE_EN
        any_nan  = s1_x_nan | s1_y_nan;
        any_snan = s1_x_snan | s1_y_snan;
        eq       = (s1_x == s1_y) | (s1_x_zero & s1_y_zero);
        if (sx != sy) begin
            lt = sx & ~(s1_x_zero & s1_y_zero);
        end else if (!sx) begin
            lt = mx < my;
        end else begin
            lt = mx > my;
        end
        if (s1_x_nan & s1_y_nan) begin
            min_v = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            max_v = min_v;
        end else if (s1_x_nan) begin
            min_v = s1_y;
            max_v = s1_y;
        end else if (s1_y_nan) begin
            min_v = s1_x;
            max_v = s1_x;
        end else if (s1_x_zero & s1_y_zero) begin
            // Zero sign decides: min prefers -0, max prefers +0, independent of order.
            min_v = {sx | sy, {(W-1){1'b0}}};
            max_v = {sx & sy, {(W-1){1'b0}}};
        end else begin
            min_v = (~lt & ~eq) ? s1_y : s1_x;
            max_v = lt ? s1_y : s1_x;
        end
`else
        any_nan  = 1'b0;
        any_snan = 1'b0;
        eq       = s1_x == s1_y;
        if (sx != sy) begin
            lt = sx;
        end else if (!sx) begin
            lt = mx < my;
        end else begin
            lt = mx > my;
        end
        min_v = (~lt & ~eq) ? s1_y : s1_x;
        max_v = lt ? s1_y : s1_x;
`endif
        res_d = '0;
        nv_d  = 1'b0;
        case (s1_op)
            OP_FEQ: begin
                res_d = {{(W-1){1'b0}}, eq & ~any_nan};
                nv_d  = any_snan;
            end
            OP_FLT: begin
                res_d = {{(W-1){1'b0}}, lt & ~any_nan};
                nv_d  = any_nan;
            end
            OP_FLE: begin
                res_d = {{(W-1){1'b0}}, (lt | eq) & ~any_nan};
                nv_d  = any_nan;
            end
            OP_FMIN: begin
                res_d = min_v;
                nv_d  = any_snan;
            end
            OP_FMAX: begin
                res_d = max_v;
                nv_d  = any_snan;
            end
            default: begin
                res_d = '0;
                nv_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_nv     <= 1'b0;
            s2_tag    <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
                s1_op    <= in_op;
                s1_x     <= in_x;
                s1_y     <= in_y;
                s1_tag   <= in_tag;
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_result <= res_d;
                    s2_nv     <= nv_d;
                    s2_tag    <= s1_tag;
                end
            end
        end
    end

    assign out_valid  = s2_valid;
    assign out_result = s2_result;
    assign out_nv     = s2_nv;
    assign out_tag    = s2_tag;

endmodule

// File: tb/tb_fcomp_pipe.sv
// Self-checking bench for fcomp_pipe: directed vectors, backpressure, reset, random stream.
module tb_fcomp_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [31:0] in_x = '0;
    logic [31:0] in_y = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_nv;
    logic [4:0]  out_tag;

    int tests = 0;
    int fails = 0;

`ifdef FCOMP_IEEE_EN
    localparam bit IEEE = 1'b1;
`else
    localparam bit IEEE = 1'b0;
`endif

    fcomp_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_nv     (out_nv),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    // Total order on values as signed integers; IEEE merges +-0, legacy puts -0 below +0.
    function automatic longint fkey(input logic [31:0] v);
        longint m;
        m = longint'(v[30:0]);
        if (v[31]) return IEEE ? -m : -m - 1;
        return m;
    endfunction

    function automatic void model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic nv);
        bit xn, yn, xs, ys;
        longint kx, ky;
        xn = IEEE && (x[30:23] == 8'hFF) && (x[22:0] != 0);
        yn = IEEE && (y[30:23] == 8'hFF) && (y[22:0] != 0);
        xs = xn && !x[22];
        ys = yn && !y[22];
        kx = fkey(x);
        ky = fkey(y);
        r  = '0;
        nv = 1'b0;
        case (op)
            3'd0: begin r = {31'b0, !xn && !yn && kx == ky}; nv = xs || ys; end
            3'd1: begin r = {31'b0, !xn && !yn && kx < ky};  nv = xn || yn; end
            3'd2: begin r = {31'b0, !xn && !yn && kx <= ky}; nv = xn || yn; end
            3'd3, 3'd4: begin
                nv = xs || ys;
                if (xn && yn) r = 32'h7FC0_0000;
                else if (xn) r = y;
                else if (yn) r = x;
                else if (kx == ky) r = (x == y) ? x : ((op == 3'd3) ? (x | y) : (x & y));
                else if (op == 3'd3) r = (kx < ky) ? x : y;
                else r = (kx > ky) ? x : y;
            end
            default: begin r = '0; nv = 1'b0; end
        endcase
    endfunction

    function automatic logic [31:0] rand_fp(input logic [31:0] other);
        logic        s;
        logic [22:0] m;
        logic [30:0] flip;
        s    = 1'($urandom_range(0, 1));
        m    = 23'($urandom);
        flip = 31'(1) << $urandom_range(0, 3);
        case ($urandom_range(0, 7))
            0, 1:    return $urandom;
            2:       return {s, 31'b0};
            3:       return {s, 8'hFF, 1'b1, m[21:0]};
            4:       return {s, 8'hFF, 1'b0, m[21:0] | 22'h1};
            5:       return {s, 8'hFF, 23'b0};
            6:       return other;
            default: return {other[31], other[30:0] ^ flip};
        endcase
    endfunction

    // Issues one op with an empty pipe and out_ready=1; called #1 after a rising edge.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tg, output logic v1, output logic v2,
                         output logic [31:0] r, output logic nv, output logic [4:0] to);
        out_ready = 1'b1;
        in_op     = op;
        in_x      = a;
        in_y      = b;
        in_tag    = tg;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        v1 = out_valid;
        @(posedge clk); #1;
        v2 = out_valid;
        r  = out_result;
        nv = out_nv;
        to = out_tag;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0 || out_nv !== 1'b0
            || out_tag !== 5'h0) begin
            fails++;
            $display("FAIL reset_state: valid=%b ready=%b res=%h nv=%b tag=%h, need 0 1 0 0 0",
                     out_valid, in_ready, out_result, out_nv, out_tag);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  t_op[16] = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd3,
                                  3'd4, 3'd3, 3'd4, 3'd4, 3'd3, 3'd5, 3'd2, 3'd1};
        logic [31:0] t_x[16] = '{32'hBF800000, 32'hBF800000, 32'hBF800000, 32'h80000000,
                                 32'h7FC00000, 32'h7FC00000, 32'h7F800001, 32'h7F800001,
                                 32'h7FC00001, 32'h00000000, 32'h00000000, 32'h80000000,
                                 32'h3F800000, 32'hBF800000, 32'h3F800000, 32'hC0000000};
        logic [31:0] t_y[16] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00000000,
                                 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000,
                                 32'h7FC00000, 32'h80000000, 32'h80000000, 32'h00000000,
                                 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF800000};
        logic [31:0] r_ieee[16] = '{32'h1, 32'h1, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h40000000,
                                    32'h7FC00000, 32'h80000000, 32'h0, 32'h0, 32'h3F800000,
                                    32'h0, 32'h1, 32'h1};
        logic        nv_ieee[16] = '{0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        logic [31:0] r_leg[16] = '{32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h40000000,
                                   32'h7FC00001, 32'h80000000, 32'h0, 32'h0, 32'h3F800000,
                                   32'h0, 32'h1, 32'h1};
        logic        v1, v2, nv;
        logic [31:0] r, er;
        logic [4:0]  to;
        logic        env;
        for (int i = 0; i < 16; i++) begin
            er  = IEEE ? r_ieee[i] : r_leg[i];
            env = IEEE ? nv_ieee[i] : 1'b0;
            do_op(t_op[i], t_x[i], t_y[i], 5'(i + 1), v1, v2, r, nv, to);
            tests++;
            if (v1 !== 1'b0 || v2 !== 1'b1) begin
                fails++;
                $display("FAIL latency[%0d]: valid c1=%b c2=%b, need 0 1", i, v1, v2);
            end
            tests++;
            if (r !== er || nv !== env || to !== 5'(i + 1)) begin
                fails++;
                $display("FAIL directed[%0d] op=%0d x=%h y=%h: got res=%h nv=%b tag=%0d, need %h %b %0d",
                         i, t_op[i], t_x[i], t_y[i], r, nv, to, er, env, i + 1);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int          next_tag;
        int          acc;
        logic [4:0]  got[$];
        next_tag  = 1;
        acc       = 0;
        out_ready = 1'b0;
        in_op     = 3'd4;
        in_x      = 32'h40400000;
        in_y      = 32'h3F800000;
        in_tag    = 5'd1;
        in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                tests++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 5'd1) begin
                    fails++;
                    $display("FAIL bp_hold[%0d]: ready=%b valid=%b tag=%0d, need 0 1 1",
                             c, in_ready, out_valid, out_tag);
                end
            end
            if (in_valid && in_ready) begin
                acc++;
                next_tag++;
            end
            @(posedge clk); #1;
            in_tag   = 5'(next_tag);
            in_valid = next_tag <= 4;
        end
        tests++;
        if (acc != 2) begin
            fails++;
            $display("FAIL bp_accepted: got %0d accepts while stalled, need 2", acc);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) next_tag++;
            if (out_valid && out_ready) got.push_back(out_tag);
            @(posedge clk); #1;
            in_tag   = 5'(next_tag);
            in_valid = next_tag <= 4;
        end
        in_valid = 1'b0;
        tests++;
        if (got.size() != 4) begin
            fails++;
            $display("FAIL bp_count: delivered %0d results, need 4", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            tests++;
            if (got[i] !== 5'(i + 1)) begin
                fails++;
                $display("FAIL bp_order[%0d]: tag %0d, need %0d", i, got[i], i + 1);
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic        v1, v2, nv;
        logic [31:0] r;
        logic [4:0]  to;
        out_ready = 1'b0;
        in_op     = 3'd4;
        in_x      = 32'h40000000;
        in_y      = 32'h3F800000;
        in_tag    = 5'd7;
        in_valid  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 32'h40000000) begin
            fails++;
            $display("FAIL rst_fill: valid=%b ready=%b res=%h, need 1 0 40000000",
                     out_valid, in_ready, out_result);
        end
        rst    = 1'b1;
        in_tag = 5'd9;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || out_tag !== 5'h0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid: valid=%b res=%h tag=%0d ready=%b, need 0 0 0 1",
                     out_valid, out_result, out_tag, in_ready);
        end
        do_op(3'd1, 32'hBF800000, 32'h3F800000, 5'd3, v1, v2, r, nv, to);
        tests++;
        if (v1 !== 1'b0 || v2 !== 1'b1 || r !== 32'h1 || to !== 5'd3) begin
            fails++;
            $display("FAIL rst_after: c1=%b c2=%b res=%h tag=%0d, need 0 1 1 3", v1, v2, r, to);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random_stream();
        localparam int N = 300;
        logic [31:0] q_res[$];
        logic        q_nv[$];
        logic [4:0]  q_tag[$];
        logic [31:0] er, prev_res;
        logic        env, prev_nv, stalled, acc;
        logic [4:0]  prev_tag;
        int          sent, got, cyc;
        sent    = 0;
        got     = 0;
        cyc     = 0;
        acc     = 1'b0;
        stalled = 1'b0;
        in_x    = rand_fp(32'h3F800000);
        in_y    = rand_fp(in_x);
        in_op   = 3'($urandom_range(0, 7));
        while (got < N && cyc < 20000) begin
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                in_x  = rand_fp(in_y);
                in_y  = rand_fp(in_x);
                in_op = 3'($urandom_range(0, 7));
            end
            in_tag = 5'(sent);
            if (!(in_valid && !acc)) in_valid = (sent < N) && ($urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) begin
                model(in_op, in_x, in_y, er, env);
                q_res.push_back(er);
                q_nv.push_back(env);
                q_tag.push_back(in_tag);
            end
            if (out_valid) begin
                if (stalled) begin
                    tests++;
                    if (out_result !== prev_res || out_nv !== prev_nv || out_tag !== prev_tag) begin
                        fails++;
                        $display("FAIL stall_stable: res=%h nv=%b tag=%0d, held %h %b %0d",
                                 out_result, out_nv, out_tag, prev_res, prev_nv, prev_tag);
                    end
                end
                if (out_ready) begin
                    tests++;
                    if (q_res.size() == 0) begin
                        fails++;
                        $display("FAIL rand_extra: result tag=%0d with nothing outstanding", out_tag);
                    end else begin
                        er  = q_res.pop_front();
                        env = q_nv.pop_front();
                        prev_tag = q_tag.pop_front();
                        if (out_result !== er || out_nv !== env || out_tag !== prev_tag) begin
                            fails++;
                            $display("FAIL rand[%0d]: got res=%h nv=%b tag=%0d, need %h %b %0d",
                                     got, out_result, out_nv, out_tag, er, env, prev_tag);
                        end
                    end
                    got++;
                end
                stalled  = !out_ready;
                prev_res = out_result;
                prev_nv  = out_nv;
                prev_tag = out_tag;
            end else begin
                stalled = 1'b0;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tests++;
        if (got != N) begin
            fails++;
            $display("FAIL rand_timeout: %0d of %0d results in %0d cycles", got, N, cyc);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fcomp_pipe.md
Name: fcomp_pipe

Overview:
Parametrised, two-stage pipelined floating-point compare/select unit for the FPU execute path. It handles FEQ, FLT, FLE, FMIN and FMAX on a configurable IEEE-style format. Valid/ready handshakes are provided on both sides, and a tag passes through for writeback routing. It reports the invalid-operation (NV) flag and, by default, handles NaN and signed zero per IEEE 754.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, mantissa (fraction) field width; total width W = 1+EXP_W+MAN_W
TAG_W, 5, width of pass-through tag (destination register id)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  unit can accept request this cycle
in_op  in  3  0=FEQ 1=FLT 2=FLE 3=FMIN 4=FMAX; 5-7 reserved
in_x  in  W  operand x
in_y  in  W  operand y
in_tag  in  TAG_W  request tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  W  compare ops: {W-1 zeros, bit}; FMIN/FMAX: selected value
out_nv  out  1  invalid-operation flag
out_tag  out  TAG_W  tag of the result

Behaviour:
- Stage S1 registers the operands, op and tag, plus a per-operand classification: is_nan, is_snan (exp all ones, mant≠0, mant MSB=0), is_zero.
- Stage S2 registers out_result, out_nv and out_tag. Each stage has its own valid bit.
- Handshake:
  - adv2 = ~s2_valid | out_ready
  - adv1 = ~s1_valid | adv2
  - in_ready = adv1
  - A transfer occurs when in_valid & in_ready. Same rule at the output.
- Bubbles collapse: an empty stage always accepts.
- Latency is exactly 2 cycles when out_ready=1. Full throughput is 1 op/cycle.
- When out_ready=0 with both stages full: in_ready=0, and all S1/S2 contents are held stable.
- out_result, out_nv and out_tag must not change while out_valid=1 and out_ready=0.
- Reset clears s1_valid and s2_valid, and sets out_result=0, out_nv=0, out_tag=0 on the next edge.
  - Reset mid-operation discards in-flight requests, and out_valid=0 the cycle after.
  - Reset overrides any simultaneous handshake.
- Ordered compare (neither operand NaN):
  - eq = (x==y) | (both zero).
  - lt:
    - signs differ: x negative and not both zero.
    - both positive: mag(x) < mag(y).
    - both negative: mag(x) > mag(y).
    - mag = {exp, mant}, compared unsigned.
  - FLE = lt | eq.
- NaN rules:
  - FEQ: result 0; NV=1 only if either operand is sNaN.
  - FLT/FLE: result 0; NV=1 if either operand is any NaN.
  - FMIN/FMAX:
    - one NaN: return the other operand.
    - both NaN: return canonical qNaN (sign 0, exp all ones, mant MSB 1, rest 0).
    - NV=1 if either operand is sNaN.
- Signed zero in selection: FMIN(-0,+0) = -0 and FMAX(-0,+0) = +0, regardless of operand order.
- Equal non-zero values in FMIN/FMAX return x.
- Reserved ops (5-7) complete normally with out_result=0 and out_nv=0.

Optional Feature:
FCOMP_IEEE_EN (defined by default in the FPU build):
- With it: NaN classification, NV generation and ±0 equivalence exactly as above.
- Without it: legacy raw-bit mode.
  - eq = bitwise equality.
  - lt = sign-magnitude ordering on raw bits, with no NaN or zero special cases (+0 vs -0 ordered by sign).
  - FMIN/FMAX select by this raw lt.
  - out_nv is constant 0.
  - The classification registers are not instantiated.
  - Handshake and latency are unchanged.

Test Plan:
- FLT x=0xBF800000 (-1.0), y=0x3F800000 (1.0), out_ready=1 → out_valid on cycle 2, out_result=1, out_nv=0; FLE with the same operands also gives 1; FEQ gives 0.
- FEQ x=0x80000000, y=0x00000000 → result 1 with FCOMP_IEEE_EN; result 0 without it.
- FLT x=0x7FC00000 (qNaN), y=0x3F800000 → result 0, out_nv=1. FEQ with the same operands → result 0, out_nv=0. FEQ with x=0x7F800001 (sNaN) → out_nv=1.
- FMIN x=0x7F800001, y=0x40000000 → 0x40000000, nv=1. FMAX with both operands qNaN → 0x7FC00000, nv=0. FMIN(0x00000000, 0x80000000) → 0x80000000.
- Backpressure: issue 4 back-to-back ops tags 1-4, hold out_ready=0 for 3 cycles → in_ready drops after 2 accepted; out_tag=1 is held stable. Release → tags 1,2,3,4 are delivered in order, with no loss or duplication.
- Assert rst for 1 cycle with both stages full → next cycle out_valid=0, out_result=0, out_tag=0, in_ready=1; the next request completes normally 2 cycles later.
